siggen_wave_pwm: RTL

Waveform synthesis and 1-bit output stage of the signal generator. It takes a frequency word from the switches and a waveform select from the button-decode logic. It produces PWM_W-bit samples from a phase accumulator: square, sawtooth, triangle, or off. A PWM modulator turns each sample into a single-bit stream that drives the pmod pin through an external RC filter. It replaces the fixed divide-by-counter square-wave toggle at the top level.

---
 rtl/siggen_wave_pwm.sv | 73 +++++++
 1 files changed

// File: rtl/siggen_wave_pwm.sv
// Phase-accumulator waveform synthesis (square/saw/triangle/off) feeding a
// PWM modulator; new samples load once per PWM frame so shape changes are glitch-free.
module siggen_wave_pwm #(
    parameter int ACC_W = 16,
    parameter int PWM_W = 8,
    parameter int FW_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [FW_W-1:0]  freq_word,
    input  logic [1:0]       wave_sel,
    output logic             pwm_out,
    output logic [PWM_W-1:0] sample,
    output logic             sample_tick
);

    localparam logic [1:0] SEL_SQUARE = 2'b00;
    localparam logic [1:0] SEL_SAW    = 2'b01;
    localparam logic [1:0] SEL_TRI    = 2'b10;
    localparam logic [1:0] SEL_OFF    = 2'b11;
    localparam logic [PWM_W-1:0] CNT_MAX = '1;

    logic [PWM_W-1:0] pwm_cnt;
    logic [ACC_W-1:0] phase;
    logic [1:0]       sel_q;
    logic [PWM_W-1:0] duty;
    logic [PWM_W-1:0] shape_val;
    logic [PWM_W-1:0] p;
    logic [PWM_W-1:0] p_doubled;
    logic             wrap;

    assign p         = phase[ACC_W-1 -: PWM_W];
    assign p_doubled = {p[PWM_W-2:0], 1'b0};
    assign wrap      = (pwm_cnt == CNT_MAX);
    assign sample    = duty;

    // Triangle: rising half doubles p, falling half is its complement so the
    // peak reads ..., 254, 255, 253, ... with no repeated value.
    always_comb begin
        shape_val = '0;
        case (wave_sel)
            SEL_SQUARE: shape_val = p[PWM_W-1] ? CNT_MAX : '0;
            SEL_SAW:    shape_val = p;
            SEL_TRI:    shape_val = p[PWM_W-1] ? ~p_doubled : p_doubled;
            default:    shape_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt     <= '0;
            phase       <= '0;
            sel_q       <= SEL_OFF;
            duty        <= '0;
            pwm_out     <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            pwm_cnt     <= pwm_cnt + 1'b1;
            sample_tick <= wrap;
            // Compare uses the pre-edge count and duty, so the output lags by one cycle.
            pwm_out     <= (sel_q != SEL_OFF) && (pwm_cnt < duty);
            if (wrap) begin
                sel_q <= wave_sel;
                duty  <= shape_val;
                if (wave_sel == SEL_OFF)
                    phase <= '0;
                else
                    phase <= phase + ACC_W'(freq_word);
            end
        end
    end

endmodule
